// File: rtl/fc8_mem_arbiter.sv
// fc8_mem_arbiter: shares the FC8 RAM port between the CPU (priority) and a DMA master,
// forcing a DMA slot after MAX_WAIT denied request cycles.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   cpu_addr/wdata/rd_en/wr_en      CPU memory request
//   cpu_rdata, cpu_rdy              CPU read data and completion/stall flag
//   dma_req/we/addr/wdata           DMA request, held until dma_ack
//   dma_ack, dma_rdata              one-cycle completion pulse and registered read data
//   mem_addr/wdata/rd_en/wr_en      RAM port (synchronous write)
//   mem_rdata                       RAM asynchronous read data
module fc8_mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    input  logic              cpu_rd_en,
    input  logic              cpu_wr_en,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_rdy,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_wdata,
    output logic              dma_ack,
    output logic [7:0]        dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    input  logic [7:0]        mem_rdata
);
    localparam logic       S_IDLE = 1'b0;
    localparam logic       S_ACK  = 1'b1;
    localparam logic [3:0] MW     = 4'(MAX_WAIT);

    logic       state;
    logic [3:0] wait_cnt;
    logic       cpu_req;
    logic       force_dma;
    logic       dma_grant;

    assign cpu_req   = cpu_rd_en | cpu_wr_en;
    assign force_dma = wait_cnt >= MW;
    // Reset masks the grant so the forced-idle bus outputs fall out of the mux below.
    assign dma_grant = rst_n & (state == S_IDLE) & dma_req & (~cpu_req | force_dma);

    always_comb begin
        mem_addr  = dma_grant ? dma_addr : cpu_addr;
        mem_wdata = dma_grant ? dma_wdata : cpu_wdata;
        mem_rd_en = rst_n & (dma_grant ? ~dma_we : cpu_rd_en);
        mem_wr_en = rst_n & (dma_grant ? dma_we : cpu_wr_en);
        cpu_rdy   = ~(dma_grant & cpu_req);
        cpu_rdata = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            dma_ack   <= 1'b0;
            dma_rdata <= 8'h00;
        end else if (dma_grant) begin
            state    <= S_ACK;
            wait_cnt <= 4'd0;
            dma_ack  <= 1'b1;
            if (!dma_we)
                dma_rdata <= mem_rdata;
        end else if (state == S_ACK) begin
            // wait_cnt is already zero here: S_ACK is only entered through a grant.
            state   <= S_IDLE;
            dma_ack <= 1'b0;
        end else begin
            dma_ack  <= 1'b0;
            wait_cnt <= !dma_req ? 4'd0 : (wait_cnt == 4'hF ? 4'hF : wait_cnt + 4'd1);
        end
    end
endmodule

// File: tb/tb_fc8_mem_arbiter.sv
// tb_fc8_mem_arbiter: directed self-checking bench for fc8_mem_arbiter.
// u1 uses MAX_WAIT=4, u0 uses MAX_WAIT=0; both see the same stimulus and each has its own RAM.
module tb_fc8_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_addr, dma_addr;
    logic [7:0]  cpu_wdata, dma_wdata;
    logic        cpu_rd_en, cpu_wr_en, dma_req, dma_we;

    logic [7:0]  cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic [15:0] mem_addr;
    logic        cpu_rdy, dma_ack, mem_rd_en, mem_wr_en;

    logic [7:0]  cpu_rdata0, dma_rdata0, mem_wdata0, mem_rdata0;
    logic [15:0] mem_addr0;
    logic        cpu_rdy0, dma_ack0, mem_rd_en0, mem_wr_en0;

    logic [7:0] ram  [0:65535];
    logic [7:0] ram0 [0:65535];

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fc8_mem_arbiter #(.ADDR_W(16), .MAX_WAIT(4)) u1 (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en),
        .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_rdata(mem_rdata)
    );

    fc8_mem_arbiter #(.ADDR_W(16), .MAX_WAIT(0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en),
        .cpu_rdata(cpu_rdata0), .cpu_rdy(cpu_rdy0),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack0), .dma_rdata(dma_rdata0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rd_en(mem_rd_en0), .mem_wr_en(mem_wr_en0),
        .mem_rdata(mem_rdata0)
    );

    // RAMs: synchronous write, asynchronous read; 0x0300 is preloaded with 8'h5A during reset.
    assign mem_rdata  = ram[mem_addr];
    assign mem_rdata0 = ram0[mem_addr0];

    always @(posedge clk) begin
        if (!rst_n)
            ram[16'h0300] <= 8'h5A;
        else if (mem_wr_en)
            ram[mem_addr] <= mem_wdata;
    end

    always @(posedge clk) begin
        if (!rst_n)
            ram0[16'h0300] <= 8'h5A;
        else if (mem_wr_en0)
            ram0[mem_addr0] <= mem_wdata0;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    // Advance past the next rising edge; inputs change and checks happen mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_rd_en = 1'b0; cpu_wr_en = 1'b1;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0000; dma_wdata = 8'h00;
        tick();
        tick();
        // Reset: requests present but all bus outputs forced idle.
        chk("rst_ack", {15'd0, dma_ack}, 16'd0);
        chk("rst_rdata", {8'd0, dma_rdata}, 16'h0000);
        chk("rst_cpu_rdy", {15'd0, cpu_rdy}, 16'd1);
        chk("rst_wr_en", {15'd0, mem_wr_en}, 16'd0);
        chk("rst_rd_en", {15'd0, mem_rd_en}, 16'd0);
        rst_n = 1'b1; cpu_wr_en = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
        tick();

        // Uncontested CPU write: STA $0020 of C3.
        cpu_addr = 16'h0020; cpu_wdata = 8'hC3; cpu_wr_en = 1'b1;
        #1;
        chk("cpu_wr_rdy", {15'd0, cpu_rdy}, 16'd1);
        chk("cpu_wr_en", {15'd0, mem_wr_en}, 16'd1);
        chk("cpu_wr_addr", mem_addr, 16'h0020);
        chk("cpu_wr_data", {8'd0, mem_wdata}, 16'h00C3);
        tick();
        cpu_wr_en = 1'b0;
        #1;
        chk("cpu_wr_ram", {8'd0, ram[16'h0020]}, 16'h00C3);
        chk("cpu_wr_no_ack", {15'd0, dma_ack}, 16'd0);

        // Idle-slot DMA read of 0x0300.
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0300;
        #1;
        chk("dmard_rd_en", {15'd0, mem_rd_en}, 16'd1);
        chk("dmard_addr", mem_addr, 16'h0300);
        tick();
        chk("dmard_ack", {15'd0, dma_ack}, 16'd1);
        chk("dmard_rdata", {8'd0, dma_rdata}, 16'h005A);
        chk("dmard_no_grant_in_ack", {15'd0, mem_rd_en}, 16'd0);
        dma_req = 1'b0;
        tick();
        chk("dmard_ack_drop", {15'd0, dma_ack}, 16'd0);

        // Starvation: CPU reads 0x0020 continuously, DMA writes 77 to 0x0010.
        cpu_rd_en = 1'b1; cpu_addr = 16'h0020;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0010; dma_wdata = 8'h77;
        #1;
        chk("starve_rdy_c1", {15'd0, cpu_rdy}, 16'd1);
        tick();
        chk("starve_rdy_c2", {15'd0, cpu_rdy}, 16'd1);
        tick();
        chk("starve_rdy_c3", {15'd0, cpu_rdy}, 16'd1);
        tick();
        chk("starve_rdy_c4", {15'd0, cpu_rdy}, 16'd1);
        chk("starve_cpu_on_bus_c4", {15'd0, mem_rd_en}, 16'd1);
        tick();
        chk("starve_rdy_c5", {15'd0, cpu_rdy}, 16'd0);
        chk("starve_wr_en_c5", {15'd0, mem_wr_en}, 16'd1);
        chk("starve_addr_c5", mem_addr, 16'h0010);
        tick();
        chk("starve_ack", {15'd0, dma_ack}, 16'd1);
        chk("starve_rdy_ack", {15'd0, cpu_rdy}, 16'd1);
        chk("starve_cpu_addr_ack", mem_addr, 16'h0020);
        chk("starve_cpu_rdata", {8'd0, cpu_rdata}, 16'h00C3);
        chk("starve_ram", {8'd0, ram[16'h0010]}, 16'h0077);
        cpu_rd_en = 1'b0; dma_req = 1'b0;
        tick();

        // Back-to-back DMA reads of 0x0300, 0x0020, 0x0010.
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0300;
        #1;
        chk("b2b_grant0", {15'd0, mem_rd_en}, 16'd1);
        chk("b2b_noack0", {15'd0, dma_ack}, 16'd0);
        tick();
        chk("b2b_ack1", {15'd0, dma_ack}, 16'd1);
        chk("b2b_nogrant1", {15'd0, mem_rd_en}, 16'd0);
        chk("b2b_rdata1", {8'd0, dma_rdata}, 16'h005A);
        dma_addr = 16'h0020;
        tick();
        chk("b2b_grant2", {15'd0, mem_rd_en}, 16'd1);
        chk("b2b_noack2", {15'd0, dma_ack}, 16'd0);
        chk("b2b_addr2", mem_addr, 16'h0020);
        tick();
        chk("b2b_ack3", {15'd0, dma_ack}, 16'd1);
        chk("b2b_rdata3", {8'd0, dma_rdata}, 16'h00C3);
        dma_addr = 16'h0010;
        tick();
        chk("b2b_grant4", {15'd0, mem_rd_en}, 16'd1);
        tick();
        chk("b2b_ack5", {15'd0, dma_ack}, 16'd1);
        chk("b2b_rdata5", {8'd0, dma_rdata}, 16'h0077);
        dma_req = 1'b0;
        tick();

        // Reset in the cycle a grant would occur.
        rst_n = 1'b0; dma_req = 1'b1; dma_addr = 16'h0020;
        #1;
        chk("midrst_no_grant", {15'd0, mem_rd_en}, 16'd0);
        chk("midrst_rdy", {15'd0, cpu_rdy}, 16'd1);
        tick();
        chk("midrst_no_ack", {15'd0, dma_ack}, 16'd0);
        chk("midrst_rdata", {8'd0, dma_rdata}, 16'h0000);
        rst_n = 1'b1;
        #1;
        chk("postrst_grant", {15'd0, mem_rd_en}, 16'd1);
        tick();
        chk("postrst_ack", {15'd0, dma_ack}, 16'd1);
        chk("postrst_rdata", {8'd0, dma_rdata}, 16'h00C3);
        dma_req = 1'b0;
        tick();

        // MAX_WAIT=0 build: CPU reads 0x0020 while DMA reads 0x0300.
        cpu_rd_en = 1'b1; cpu_addr = 16'h0020;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0300;
        #1;
        chk("mw0_rdy_g1", {15'd0, cpu_rdy0}, 16'd0);
        chk("mw0_addr_g1", mem_addr0, 16'h0300);
        tick();
        chk("mw0_ack1", {15'd0, dma_ack0}, 16'd1);
        chk("mw0_rdata1", {8'd0, dma_rdata0}, 16'h005A);
        chk("mw0_rdy_ack1", {15'd0, cpu_rdy0}, 16'd1);
        chk("mw0_cpu_addr_ack1", mem_addr0, 16'h0020);
        chk("mw0_cpu_rdata_ack1", {8'd0, cpu_rdata0}, 16'h00C3);
        tick();
        chk("mw0_rdy_g2", {15'd0, cpu_rdy0}, 16'd0);
        chk("mw0_noack_g2", {15'd0, dma_ack0}, 16'd0);
        tick();
        chk("mw0_ack2", {15'd0, dma_ack0}, 16'd1);
        chk("mw0_rdy_ack2", {15'd0, cpu_rdy0}, 16'd1);
        cpu_rd_en = 1'b0; dma_req = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
